// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS registers, TX FIFO, serialiser.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module mmio_uart_tx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       data_q;
    logic             bit_done;
    logic             tx_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             empty;
    logic             ovf;

    logic             hit_data;
    logic             hit_stat;
    logic             do_push;
    logic             push_drop;
    logic             do_pop;
    logic             clr_ovf;
    logic [31:0]      status;
    logic             unused_wdata;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign hit_data  = (bus_addr == BASE_ADDR);
    assign hit_stat  = (bus_addr == BASE_ADDR + 32'd4);
    assign do_push   = bus_we & hit_data & ~full;
    assign push_drop = bus_we & hit_data & full;
    assign clr_ovf   = bus_we & hit_stat & bus_wdata[3];
    assign status    = {28'd0, ovf, (state != IDLE), empty, full};
    assign unused_wdata = &{1'b0, bus_wdata[31:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_ready <= 1'b0;
            bus_rdata <= 32'd0;
        end else begin
            bus_ready <= (bus_we | bus_re) & (hit_data | hit_stat);
            bus_rdata <= (bus_re & ~bus_we & hit_stat) ? status : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf <= 1'b0;
        else if (push_drop)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // NOTE: storage array is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= bus_wdata[7:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    assign bit_done = (bit_cnt == CNT_LAST);
    assign do_pop   = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
    assign tx_busy  = ~empty | (state != IDLE);

    // Every state lasts exactly one full bit period, so wrapping equals reset-on-entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bit_cnt <= '0;
        else if ((state == IDLE) || bit_done)
            bit_cnt <= '0;
        else
            bit_cnt <= bit_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_idx <= 3'd0;
            data_q  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        data_q <= mem[rptr[AW-1:0]];
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done)
                        state <= STOP;
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (do_pop) begin
                            data_q <= mem[rptr[AW-1:0]];
                            state  <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:  tx_next = 1'b0;
            DATA:   tx_next = data_q[bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = ^data_q;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // Registered line output keeps tx glitch-free; it lags the FSM by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tx <= 1'b1;
        else
            tx <= tx_next;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table-driven register accesses plus
// logged-waveform checks of frames, overflow, contiguity and async reset.
module tb_mmio_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int LOG_N = 8192;

    logic        clk;
    logic        reset;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        tx;
    logic        tx_busy;

    mmio_uart_tx #(
        .CLK_HZ    (50_000_000),
        .BAUD      (5_000_000),
        .FIFO_DEPTH(8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter; log[c] holds outputs sampled on the falling edge after rising edge c.
    int   cyc = 0;
    logic tx_log   [LOG_N];
    logic busy_log [LOG_N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            tx_log[cyc]   <= tx;
            busy_log[cyc] <= tx_busy;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic bus_op(input string name, input logic we, input logic re,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_ready, input logic [31:0] exp_rdata);
        @(negedge clk);
        bus_we    = we;
        bus_re    = re;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(negedge clk);
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        check({name, " ready"}, bus_ready, exp_ready);
        check({name, " rdata"}, bus_rdata, exp_rdata);
        @(negedge clk);
        check({name, " ready_drop"}, bus_ready, 32'd0);
        check({name, " rdata_drop"}, bus_rdata, 32'd0);
    endtask

    logic [7:0] wq[$];

    // Back-to-back DATA writes of wq; n0 is the rising edge that samples the first.
    task automatic write_burst(output int n0);
        n0 = 0;
        for (int i = 0; i < wq.size(); i++) begin
            @(negedge clk);
            if (i == 0) n0 = cyc + 1;
            bus_we    = 1'b1;
            bus_re    = 1'b0;
            bus_addr  = BASE;
            bus_wdata = {24'd0, wq[i]};
        end
        @(negedge clk);
        bus_we    = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
    endtask

    task automatic check_frame(input int start, input logic [7:0] b, input string name);
        logic e;
        logic [CPB-1:0] s;
        logic [CPB-1:0] ex;
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)                         e = 1'b0;
            else if (k <= 8)                    e = b[k-1];
            else if (NBITS == 11 && k == 9)     e = ^b;
            else                                e = 1'b1;
            for (int m = 0; m < CPB; m++) s[m] = tx_log[start + k * CPB + m];
            ex = e ? '1 : '0;
            check($sformatf("%s bit%0d", name, k), 32'(s), 32'(ex));
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int zeros;

        vecs[0] = '{"stat_rd",     1'b0, 1'b1, BASE + 32'd4, 32'd0,     1'b1, 32'h2};
        vecs[1] = '{"data_rd",     1'b0, 1'b1, BASE,         32'd0,     1'b1, 32'h0};
        vecs[2] = '{"off8_rd",     1'b0, 1'b1, BASE + 32'd8, 32'd0,     1'b0, 32'h0};
        vecs[3] = '{"below_rd",    1'b0, 1'b1, BASE - 32'd4, 32'd0,     1'b0, 32'h0};
        vecs[4] = '{"stat_wr",     1'b1, 1'b0, BASE + 32'd4, 32'h8,     1'b1, 32'h0};
        vecs[5] = '{"we_re_stat",  1'b1, 1'b1, BASE + 32'd4, 32'h0,     1'b1, 32'h0};
        vecs[6] = '{"off8_wr",     1'b1, 1'b0, BASE + 32'd8, 32'h41,    1'b0, 32'h0};
        vecs[7] = '{"stat_rd2",    1'b0, 1'b1, BASE + 32'd4, 32'd0,     1'b1, 32'h2};

        reset     = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", tx, 32'd1);
        check("rst busy", tx_busy, 32'd0);
        check("rst ready", bus_ready, 32'd0);
        check("rst rdata", bus_rdata, 32'd0);
        reset = 1'b1;

        // Register access table from the reset state
        for (int i = 0; i < 8; i++)
            bus_op(vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_ready, vecs[i].exp_rdata);
        check("idle tx", tx, 32'd1);
        check("idle busy", tx_busy, 32'd0);

        // Single frame 0x55
        wq = {8'h55};
        write_burst(n);
        wait_until(n + FL + 4);
        check("f55 latency", 32'(tx_log[n + 1]), 32'd1);
        check_frame(n + 2, 8'h55, "f55");
        check("f55 busy_end", 32'(busy_log[n + FL]), 32'd1);
        check("f55 busy_drop", 32'(busy_log[n + FL + 1]), 32'd0);
        check("f55 idle_after", 32'(tx_log[n + FL + 2]), 32'd1);

        // Ten back-to-back writes: one popped, eight buffered, tenth dropped
        wq = {};
        for (int i = 0; i < 10; i++) wq.push_back(8'(i));
        write_burst(n);
        bus_op("ovf stat", 1'b0, 1'b1, BASE + 32'd4, 32'd0, 1'b1, 32'hD);
        wait_until(n + 9 * FL + 4);
        for (int j = 0; j < 9; j++)
            check_frame(n + 2 + j * FL, 8'(j), $sformatf("burst%0d", j));
        check("burst busy_end", 32'(busy_log[n + 9 * FL]), 32'd1);
        check("burst busy_drop", 32'(busy_log[n + 9 * FL + 1]), 32'd0);
        check("burst idle_after", 32'(tx_log[n + 9 * FL + 2]), 32'd1);

        // Overflow is sticky until STATUS is written with bit3 set
        bus_op("ovf sticky", 1'b0, 1'b1, BASE + 32'd4, 32'd0, 1'b1, 32'hA);
        bus_op("wr stat 7", 1'b1, 1'b0, BASE + 32'd4, 32'h7, 1'b1, 32'h0);
        bus_op("ovf kept", 1'b0, 1'b1, BASE + 32'd4, 32'd0, 1'b1, 32'hA);
        bus_op("wr stat 8", 1'b1, 1'b0, BASE + 32'd4, 32'h8, 1'b1, 32'h0);
        bus_op("ovf clr", 1'b0, 1'b1, BASE + 32'd4, 32'd0, 1'b1, 32'h2);
        bus_op("off8 after", 1'b0, 1'b1, BASE + 32'd8, 32'd0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of data bit 4 of the first of three frames
        wq = {8'hA5, 8'hA6, 8'hA7};
        write_burst(n);
        wait_until(n + 56);
        check("pre_rst tx", tx, 32'd0);
        reset = 1'b0;
        #1;
        check("async tx", tx, 32'd1);
        check("async busy", tx_busy, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        r0 = cyc;
        bus_op("post_rst stat", 1'b0, 1'b1, BASE + 32'd4, 32'd0, 1'b1, 32'h2);
        wait_until(r0 + 300);
        zeros = 0;
        for (int c = r0; c < r0 + 298; c++) if (tx_log[c] !== 1'b1) zeros++;
        check("post_rst quiet", zeros, 32'd0);
        check("post_rst busy", tx_busy, 32'd0);

        // Parity-relevant bytes (bit 9 is parity when enabled, else stop)
        wq = {8'h07, 8'h03};
        write_burst(n);
        wait_until(n + 2 * FL + 4);
        check_frame(n + 2, 8'h07, "f07");
        check_frame(n + 2 + FL, 8'h03, "f03");
        check("par idle_after", 32'(tx_log[n + 2 + 2 * FL]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter sitting directly downstream of the `cpu` core's data bus: it consumes CPU store traffic to a fixed address window, buffers bytes in a small FIFO and serialises them 8N1 on `tx`. It is the CPU's console output and the first peripheral on the system bus next to data memory. A status register lets firmware poll fullness, activity and overflow.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer divide, must be ≥ 2).
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two, 2..64.
- `BASE_ADDR`, 32'h1000_0000: word-aligned base of the 8-byte register window.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_addr`  in  32  byte address from CPU.
- `bus_wdata`  in  32  store data.
- `bus_we`  in  1  write strobe, one cycle per store.
- `bus_re`  in  1  read strobe, one cycle per load.
- `bus_rdata`  out  32  registered read data.
- `bus_ready`  out  1  one-cycle acknowledge for accesses in window.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high while FIFO non-empty or a frame is in progress.

## Operation
- Registers: `BASE+0` DATA (write: push `bus_wdata[7:0]`; read: 0). `BASE+4` STATUS (read): bit0 full, bit1 empty, bit2 frame active, bit3 overflow (sticky), bits[31:4] 0. Writing STATUS with bit3=1 clears overflow; other bits ignored.
- Other addresses: no effect, no `bus_ready`, `bus_rdata` = 0. `bus_we` and `bus_re` together: write takes precedence, read returns 0.
- FIFO: circular, pointers one bit wider than index; full = MSBs differ and index bits equal. Push when full is dropped and sets overflow — fullness evaluated before any same-cycle pop, so a push at full is dropped even if a pop occurs in that cycle.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: `tx`=1; if FIFO non-empty (registered count), pop into shift register, go START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits LSB first, `CLKS_PER_BIT` cycles each, 3-bit bit index.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles; at end, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
- Bit timer counts 0..`CLKS_PER_BIT`-1, wraps and advances state/bit on terminal count; resets to 0 on every state entry.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `bus_rdata`=0, `bus_ready`=0, FSM IDLE, FIFO empty, overflow 0. Reset is asynchronous: asserting mid-frame forces `tx` high immediately, discards FIFO contents and aborts the frame.
- Bus: access sampled at edge N; `bus_ready` and `bus_rdata` valid during cycle N+1 only, then return to 0.
- Latency: DATA write sampled at edge N into empty FIFO with FSM idle → pop at edge N+1 → `tx` falls after edge N+2.
- Frame length: 10×`CLKS_PER_BIT` cycles (11× with parity). Consecutive queued bytes are contiguous frames.
- STATUS read reflects state registered at the sampling edge.
- `tx_busy` = FIFO non-empty OR FSM not IDLE, combinational from registers.

## Configuration
- `UART_TX_PARITY_EN`: when defined, PARITY state inserted between DATA and STOP, driving even parity (XOR of 8 data bits) for `CLKS_PER_BIT` cycles; frame 11 bits. When undefined, no PARITY state, frame 8N1, 10 bits. Register map unchanged either way.

## Test plan
(`CLK_HZ`=50_000_000, `BAUD`=5_000_000 → `CLKS_PER_BIT`=10, `FIFO_DEPTH`=8, default base.)
- Reset, release, read `BASE+4` → `bus_rdata`=0x2 one cycle later with `bus_ready`=1; `tx`=1, `tx_busy`=0.
- Write 0x55 to `BASE+0` at edge N → `tx` low from N+2 for 10 clks, then 1,0,1,0,1,0,1,0 10 clks each, stop high; frame 100 clks; `tx_busy` drops after stop.
- Ten back-to-back DATA writes (0x00..0x09) → first popped at once, 8 buffered, 10th dropped; STATUS=0xD (full, active, overflow); nine contiguous frames 0x00..0x08, no gap, 900 clks.
- After previous test, write 0x8 to `BASE+4` → next STATUS read has bit3=0; read of `BASE+8` → no `bus_ready`, `bus_rdata`=0.
- Queue 3 bytes, assert `reset` mid data bit 4 of first frame → `tx`=1 same cycle; after release STATUS=0x2 and no further frames.
- With `UART_TX_PARITY_EN`: write 0x07 → parity bit 1, 0x03 → parity bit 0; each frame 110 clks.
